// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job arbiter: FSM state encoding and default datapath widths.
package rsa_pkg;

  localparam int RSA_WIDTH  = 32;
  localparam int RSA_E_BITS = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } arb_state_e;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping at NUM_REQ.
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  logic [ID_W-1:0] k;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    k         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any && req[k]) begin
        any       = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = k;
      end
    end
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// Round-robin job sequencer in front of one RSA modexp core; one job in flight at a time.
// Optional watchdog on the core wait is enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa_job_arbiter
  import rsa_pkg::*;
#(
  parameter int WIDTH          = RSA_WIDTH,
  parameter int E_BITS         = RSA_E_BITS,
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]  req_base,
  input  logic [NUM_REQ*E_BITS-1:0] req_exp,
  output logic                      core_start,
  output logic [WIDTH-1:0]          core_M,
  output logic [E_BITS-1:0]         core_E,
  input  logic                      core_done,
  input  logic [WIDTH-1:0]          core_C,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [WIDTH-1:0]          resp_data,
  output logic                      resp_err,
  output logic                      busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("rsa_job_arbiter: NUM_REQ must be in 2..8");
  end
  if ((1 << ID_W) < NUM_REQ) begin : g_bad_id_w
    $error("rsa_job_arbiter: ID_W too narrow for NUM_REQ");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("rsa_job_arbiter: TIMEOUT_CYCLES must be positive");
  end

  arb_state_e          state, state_n;
  logic [ID_W-1:0]     rr_ptr, cur_id, grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                grant_any;
  logic [WIDTH-1:0]    sel_base;
  logic [E_BITS-1:0]   sel_exp;
  logic                timed_out;

  rr_grant #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_grant (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // One-hot grant, so OR-ing the selected slots is a plain mux.
  always_comb begin
    sel_base = '0;
    sel_exp  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_base = sel_base | req_base[i*WIDTH +: WIDTH];
        sel_exp  = sel_exp  | req_exp[i*E_BITS +: E_BITS];
      end
    end
  end

  // Gated by rst so no requester sees an accept while reset is being sampled.
  assign req_ready  = (rst && state == IDLE) ? grant : '0;
  assign core_start = (state == ISSUE);
  assign busy       = (state != IDLE);

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                wait_cnt <= '0;
    else if (state == ISSUE) wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
  end

  assign timed_out = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // A done arriving in the same cycle as the timeout still wins.
  always_ff @(posedge clk) begin
    if (!rst)                                            resp_err <= 1'b0;
    else if (state == WAIT && !core_done && timed_out)   resp_err <= 1'b1;
    else if (state == RESP && resp_ready)                resp_err <= 1'b0;
  end
`else
  assign timed_out = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant_any)              state_n = ISSUE;
      ISSUE:                               state_n = WAIT;
      WAIT:    if (core_done || timed_out) state_n = RESP;
      RESP:    if (resp_ready)             state_n = IDLE;
      default:                             state_n = IDLE;
    endcase
  end

  // Operands stay put through WAIT: the core walks the exponent bits for the whole operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr     <= '0;
      cur_id     <= '0;
      core_M     <= '0;
      core_E     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          core_M <= sel_base;
          core_E <= sel_exp;
          cur_id <= grant_idx;
          rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        WAIT: if (core_done) begin
          resp_data  <= core_C;
          resp_id    <= cur_id;
          resp_valid <= 1'b1;
        end else if (timed_out) begin
          resp_data  <= '0;
          resp_id    <= cur_id;
          resp_valid <= 1'b1;
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
